uart_bist_top: RTL and testbench



---
 rtl/uart_bist_top.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_uart_bist_top.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bist_top.sv
// -----------------------------------------------------------------------------
// uart_bist_top
// UART echo block with a built-in self-test mode.
//   Normal mode (op_mode=0): 8N1 frames on serial_in are received and every
//   byte with a good stop bit is retransmitted on serial_out.
//   BIST mode (op_mode=1): an LFSR byte sequence is sent through an internal
//   TX->RX loopback. Each returned byte is compared with what was sent, and any
//   mismatch or missing byte sets the sticky m_i_faulty flag.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   serial_in    UART RX line, idle high
//   temp         receive inhibit (1 holds the receiver in IDLE)
//   op_mode      0 = normal echo, 1 = BIST
//   serial_out   UART TX line, idle high (held high in BIST mode)
//   baudrate_clk divided bit clock, period DIV clocks
//   m_i_faulty   sticky BIST fault flag
// -----------------------------------------------------------------------------
module uart_bist_top #(
    parameter int unsigned DIV           = 430,
    parameter int unsigned BIST_PATTERNS = 8,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5,
    parameter bit          FAULT_INJECT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic temp,
    input  logic op_mode,
    output logic serial_out,
    output logic baudrate_clk,
    output logic m_i_faulty
);

    localparam int CW = $clog2(DIV);
    localparam int PW = $clog2(BIST_PATTERNS + 1);
    localparam int TIMEOUT_TICKS = 12;
    localparam logic [7:0] FI_MASK = FAULT_INJECT ? 8'h01 : 8'h00;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_LOADED, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {B_IDLE, B_LOAD, B_WAIT, B_DONE} bist_state_t;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    in_sync;
    logic          op_prev;
    logic          bist_enter;
    logic          force_idle;
    logic          rx_line;

    rx_state_t   rx_state, rx_state_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic [2:0]  rx_idx, rx_idx_n;
    logic [7:0]  rx_data, rx_data_n;
    logic        rx_valid, rx_valid_n;

    tx_state_t   tx_state, tx_state_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic [2:0]  tx_idx, tx_idx_n;
    logic        tx_line, tx_line_n;
    logic        tx_load;
    logic [7:0]  tx_byte;

    bist_state_t bist_state, bist_state_n;
    logic [7:0]  lfsr, lfsr_n;
    logic        lfsr_fb;
    logic [PW-1:0] pat_cnt, pat_cnt_n;
    logic [3:0]  tick_cnt, tick_cnt_n;
    logic        fault, fault_n;
    logic        bist_load;
    logic        bist_advance;

    // Baud generator: tick marks the last clock of each bit period; the
    // divided clock is registered so it leaves the chip glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            baudrate_clk <= 1'b0;
        end else begin
            if (tick)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            baudrate_clk <= (cnt < CW'(DIV / 2));
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

    // serial_in comes straight from a board pin, so it is synchronised before
    // use; bits are stable for a full period, so the delay costs nothing.
    // op_prev tracks the mode so both edges of op_mode can force RX/TX idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_sync <= 2'b11;
            op_prev <= 1'b0;
        end else begin
            in_sync <= {in_sync[0], serial_in};
            op_prev <= op_mode;
        end
    end

    assign bist_enter = op_mode & ~op_prev;
    assign force_idle = op_mode ^ op_prev;
    assign rx_line    = op_mode ? tx_line : in_sync[1];

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_idx   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_shift <= rx_shift_n;
            rx_idx   <= rx_idx_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
        end
    end

    // Receiver: one sample per tick, LSB first. temp only gates start
    // detection, so a frame already under way always completes.
    always_comb begin
        rx_state_n = rx_state;
        rx_shift_n = rx_shift;
        rx_idx_n   = rx_idx;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        if (force_idle) begin
            rx_state_n = RX_IDLE;
        end else if (tick) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!temp && !rx_line) begin
                        rx_state_n = RX_DATA;
                        rx_idx_n   = '0;
                    end
                end
                RX_DATA: begin
                    rx_shift_n = {rx_line, rx_shift[7:1]};
                    rx_idx_n   = rx_idx + 1'b1;
                    if (rx_idx == 3'd7)
                        rx_state_n = RX_STOP;
                end
                RX_STOP: begin
                    if (rx_line) begin
                        rx_valid_n = 1'b1;
                        rx_data_n  = rx_shift;
                    end
                    rx_state_n = RX_IDLE;
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

    assign tx_load = op_mode ? bist_load : rx_valid;
    assign tx_byte = op_mode ? lfsr : rx_data;

    // Transmitter state register; the line is registered so serial_out only
    // changes on tick edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_idx   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_shift <= tx_shift_n;
            tx_idx   <= tx_idx_n;
            tx_line  <= tx_line_n;
        end
    end

    // Transmitter: a load is taken on any clock while idle, then the frame
    // starts on the next tick. Loads arriving while busy are ignored.
    always_comb begin
        tx_state_n = tx_state;
        tx_shift_n = tx_shift;
        tx_idx_n   = tx_idx;
        tx_line_n  = tx_line;
        if (force_idle) begin
            tx_state_n = TX_IDLE;
            tx_line_n  = 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_line_n = 1'b1;
                    if (tx_load) begin
                        tx_shift_n = tx_byte;
                        tx_state_n = TX_LOADED;
                    end
                end
                TX_LOADED: begin
                    if (tick) begin
                        tx_line_n  = 1'b0;
                        tx_state_n = TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx_line_n  = tx_shift[0];
                        tx_idx_n   = '0;
                        tx_state_n = TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_idx == 3'd7) begin
                            tx_line_n  = 1'b1;
                            tx_state_n = TX_STOP;
                        end else begin
                            tx_line_n  = tx_shift[1];
                            tx_shift_n = {1'b0, tx_shift[7:1]};
                            tx_idx_n   = tx_idx + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick)
                        tx_state_n = TX_IDLE;
                end
                default: begin
                    tx_state_n = TX_IDLE;
                    tx_line_n  = 1'b1;
                end
            endcase
        end
    end

    assign serial_out = op_mode ? 1'b1 : tx_line;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // BIST state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bist_state <= B_IDLE;
            lfsr       <= LFSR_SEED;
            pat_cnt    <= '0;
            tick_cnt   <= '0;
            fault      <= 1'b0;
        end else begin
            bist_state <= bist_state_n;
            lfsr       <= lfsr_n;
            pat_cnt    <= pat_cnt_n;
            tick_cnt   <= tick_cnt_n;
            fault      <= fault_n;
        end
    end

    // BIST sequencer: send a pattern, wait for the looped-back byte or a
    // timeout, then step the LFSR. Leaving BIST mode aborts the run but keeps
    // the fault flag so software can still read the result.
    always_comb begin
        bist_state_n = bist_state;
        lfsr_n       = lfsr;
        pat_cnt_n    = pat_cnt;
        tick_cnt_n   = tick_cnt;
        fault_n      = fault;
        bist_load    = 1'b0;
        bist_advance = 1'b0;
        if (!op_mode) begin
            bist_state_n = B_IDLE;
        end else if (bist_enter) begin
            bist_state_n = B_LOAD;
            lfsr_n       = LFSR_SEED;
            pat_cnt_n    = '0;
            fault_n      = 1'b0;
        end else begin
            case (bist_state)
                B_LOAD: begin
                    bist_load    = 1'b1;
                    tick_cnt_n   = '0;
                    bist_state_n = B_WAIT;
                end
                B_WAIT: begin
                    if (rx_valid) begin
                        if ((rx_data ^ FI_MASK) != lfsr)
                            fault_n = 1'b1;
                        bist_advance = 1'b1;
                    end else if (tick) begin
                        if (tick_cnt == 4'(TIMEOUT_TICKS - 1)) begin
                            fault_n      = 1'b1;
                            bist_advance = 1'b1;
                        end else begin
                            tick_cnt_n = tick_cnt + 1'b1;
                        end
                    end
                    if (bist_advance) begin
                        lfsr_n    = {lfsr[6:0], lfsr_fb};
                        pat_cnt_n = pat_cnt + 1'b1;
                        if (pat_cnt == PW'(BIST_PATTERNS - 1))
                            bist_state_n = B_DONE;
                        else
                            bist_state_n = B_LOAD;
                    end
                end
                B_DONE:  bist_state_n = B_DONE;
                default: bist_state_n = B_IDLE;
            endcase
        end
    end

    assign m_i_faulty = fault;

endmodule

// File: tb/tb_uart_bist_top.sv
// -----------------------------------------------------------------------------
// tb_uart_bist_top
// Self-checking bench for uart_bist_top. Two instances share all inputs: one
// with the fault-injection hook off, one with it on. Echoed bytes are
// predicted into a queue when a frame is driven and popped when the echo
// appears on serial_out.
// -----------------------------------------------------------------------------
module tb_uart_bist_top;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst;
    logic serial_in;
    logic temp;
    logic op_mode;
    logic serial_out, baudrate_clk, m_i_faulty;
    logic fi_serial_out, fi_baudrate_clk, fi_m_i_faulty;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int last_stop_edge = 0;
    logic [7:0] exp_q[$];

    uart_bist_top #(
        .DIV(DIV), .BIST_PATTERNS(8), .LFSR_SEED(8'hA5), .FAULT_INJECT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .temp(temp),
        .op_mode(op_mode), .serial_out(serial_out),
        .baudrate_clk(baudrate_clk), .m_i_faulty(m_i_faulty)
    );

    uart_bist_top #(
        .DIV(DIV), .BIST_PATTERNS(8), .LFSR_SEED(8'hA5), .FAULT_INJECT(1'b1)
    ) dut_fi (
        .clk(clk), .rst(rst), .serial_in(serial_in), .temp(temp),
        .op_mode(op_mode), .serial_out(fi_serial_out),
        .baudrate_clk(fi_baudrate_clk), .m_i_faulty(fi_m_i_faulty)
    );

    // 15 time-unit clock.
    always begin
        #7 clk = 1'b1;
        #8 clk = 1'b0;
    end

    // Clock edges since reset release; a multiple of DIV marks the edge on
    // which the DUT samples/updates its serial state.
    always @(posedge clk) begin
        if (rst)
            edge_n <= 0;
        else
            edge_n <= edge_n + 1;
    end

    // Safety net so the run can never hang.
    initial begin
        #(15 * 50000);
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick_edge();
        do begin
            @(posedge clk);
            #1;
        end while (edge_n % DIV != 0);
    endtask

    // Drive one tick-aligned 8N1 frame; predict an echo when the receiver is
    // enabled and the stop bit is good.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        if (temp == 1'b0 && stop_bit == 1'b1)
            exp_q.push_back(d);
        wait_tick_edge();
        serial_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_tick_edge();
            serial_in = d[i];
        end
        wait_tick_edge();
        serial_in = stop_bit;
        wait_tick_edge();
        last_stop_edge = edge_n;
        serial_in = 1'b1;
    endtask

    // Wait for the echoed start bit, check its timing, then sample mid-bit.
    task automatic check_echo(input string name);
        logic [7:0] got;
        logic [7:0] want;
        int fall_edge;
        bit seen;
        seen = 1'b0;
        fall_edge = -1;
        got = '0;
        for (int c = 0; c < 3 * DIV; c++) begin
            @(posedge clk);
            #1;
            if (serial_out === 1'b0) begin
                seen = 1'b1;
                fall_edge = edge_n;
                break;
            end
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s_queue: start seen=%0d, required a predicted byte", name, seen);
            return;
        end
        want = exp_q.pop_front();
        if (!seen) begin
            bad++;
            $display("[TB] FAIL %s_start: no start bit in %0d clocks, required echo of %h", name, 3 * DIV, want);
            return;
        end
        if (fall_edge !== last_stop_edge + DIV) begin
            bad++;
            $display("[TB] FAIL %s_timing: start at edge %0d, required edge %0d", name, fall_edge, last_stop_edge + DIV);
        end
        wait_clks(DIV / 2);
        total++;
        if (serial_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_startbit: got %b, required 0", name, serial_out);
        end
        for (int i = 0; i < 8; i++) begin
            wait_clks(DIV);
            got[i] = serial_out;
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s_data: got %h, required %h", name, got, want);
        end
        wait_clks(DIV);
        total++;
        if (serial_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_stopbit: got %b, required 1", name, serial_out);
        end
    endtask

    task automatic expect_silence(input string name, input int ticks);
        int lows;
        lows = 0;
        for (int c = 0; c < ticks * DIV; c++) begin
            @(posedge clk);
            #1;
            if (serial_out !== 1'b1)
                lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("[TB] FAIL %s: serial_out low on %0d clocks, required 0", name, lows);
        end
    endtask

    task automatic test_reset();
        int errs;
        rst = 1'b1;
        serial_in = 1'b0;
        temp = 1'b1;
        op_mode = 1'b0;
        wait_clks(2 * DIV);
        total++;
        if (serial_out !== 1'b1 || fi_serial_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_serial_out: got %b/%b, required 1/1", serial_out, fi_serial_out);
        end
        total++;
        if (m_i_faulty !== 1'b0 || fi_m_i_faulty !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_faulty: got %b/%b, required 0/0", m_i_faulty, fi_m_i_faulty);
        end
        total++;
        if (baudrate_clk !== 1'b0 || fi_baudrate_clk !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_baud: got %b/%b, required 0/0", baudrate_clk, fi_baudrate_clk);
        end
        serial_in = 1'b1;
        rst = 1'b0;
        errs = 0;
        for (int c = 0; c < 3 * DIV; c++) begin
            @(posedge clk);
            #1;
            if (baudrate_clk !== (((edge_n - 1) % DIV) < DIV / 2))
                errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL baud_pattern: %0d wrong samples, required 0", errs);
        end
    endtask

    task automatic test_echo();
        temp = 1'b0;
        send_frame(8'h75, 1'b1);
        check_echo("echo_75");
    endtask

    task automatic test_inhibit();
        temp = 1'b1;
        send_frame(8'h75, 1'b1);
        expect_silence("inhibit_silent", 12);
        temp = 1'b0;
    endtask

    task automatic test_framing();
        send_frame(8'h0F, 1'b0);
        expect_silence("framing_silent", 12);
        send_frame(8'h99, 1'b1);
        check_echo("echo_99");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1);
        check_echo("echo_00");
        send_frame(8'hFF, 1'b1);
        check_echo("echo_ff");
        send_frame(8'h3C, 1'b1);
        check_echo("echo_3c");
    endtask

    task automatic test_bist();
        int out_errs;
        int fault_errs;
        out_errs = 0;
        fault_errs = 0;
        temp = 1'b0;
        op_mode = 1'b1;
        for (int c = 1; c <= 120 * DIV; c++) begin
            @(posedge clk);
            #1;
            if (serial_out !== 1'b1 || fi_serial_out !== 1'b1)
                out_errs++;
            if (m_i_faulty !== 1'b0)
                fault_errs++;
            if (c == 9 * DIV) begin
                total++;
                if (fi_m_i_faulty !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL bist_fi_early: got %b, required 0 before first compare", fi_m_i_faulty);
                end
            end
            if (c == 14 * DIV) begin
                total++;
                if (fi_m_i_faulty !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL bist_fi_detect: got %b, required 1 after first compare", fi_m_i_faulty);
                end
            end
        end
        total++;
        if (out_errs != 0) begin
            bad++;
            $display("[TB] FAIL bist_serial_out: %0d clocks not high, required 0", out_errs);
        end
        total++;
        if (fault_errs != 0) begin
            bad++;
            $display("[TB] FAIL bist_pass_faulty: %0d clocks flagged, required 0", fault_errs);
        end
    endtask

    task automatic test_bist_abort();
        op_mode = 1'b0;
        wait_clks(2 * DIV);
        total++;
        if (fi_m_i_faulty !== 1'b1 || m_i_faulty !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_flag_kept: got %b/%b, required 0/1", m_i_faulty, fi_m_i_faulty);
        end
        total++;
        if (serial_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_line_idle: got %b, required 1", serial_out);
        end
        send_frame(8'h5A, 1'b1);
        check_echo("echo_after_bist");
    endtask

    task automatic test_reset_clears();
        rst = 1'b1;
        wait_clks(2);
        total++;
        if (fi_m_i_faulty !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_clears_fault: got %b, required 0", fi_m_i_faulty);
        end
        rst = 1'b0;
        wait_clks(2);
    endtask

    initial begin
        test_reset();
        test_echo();
        test_inhibit();
        test_framing();
        test_back_to_back();
        test_bist();
        test_bist_abort();
        test_reset_clears();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
